serial_para_paralelo: RTL and testbench

Receive-side deserializer that consumes the serial bitstream produced by the parallel-to-serial stage. It sits directly downstream of that stage's serial output.
- Shifts in LARGURA bits, LSB first, qualified by a per-bit strobe.
- Presents the assembled word on a parallel output under a valid/ready handshake.
- Flags bits lost while a completed word is still waiting to be accepted.

---
 rtl/serial_para_paralelo.sv | 93 +++++++++
 tb/tb_serial_para_paralelo.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_para_paralelo.sv
// Serial-to-parallel receiver: LSB-first bits under a strobe, word out under valid/ready.
// Optional even-parity trailer bit enabled by defining PARIDADE_EN.
module serial_para_paralelo #(
  parameter int LARGURA = 6
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               limpar,
  input  logic               entrada_serial,
  input  logic               bit_valido,
  input  logic               pronto_consumidor,
  output logic [LARGURA-1:0] saida_paralela,
  output logic               dado_valido,
  output logic               sobrescrita,
  output logic               erro_paridade
);

`ifdef PARIDADE_EN
  localparam int NBITS = LARGURA + 1;
`else
  localparam int NBITS = LARGURA;
`endif
  localparam int CW = $clog2(NBITS + 1);

  typedef enum logic {RECEBENDO, CHEIO} estado_t;

  estado_t            estado;
  logic [CW-1:0]      contador;
  logic [LARGURA-1:0] deslocamento;
  logic [LARGURA-1:0] proximo;
  logic               ultimo;

  assign proximo = {entrada_serial, deslocamento[LARGURA-1:1]};
  assign ultimo  = (contador == CW'(NBITS - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      estado         <= RECEBENDO;
      contador       <= '0;
      deslocamento   <= '0;
      saida_paralela <= '0;
      dado_valido    <= 1'b0;
      sobrescrita    <= 1'b0;
      erro_paridade  <= 1'b0;
    end else if (limpar) begin
      estado         <= RECEBENDO;
      contador       <= '0;
      deslocamento   <= '0;
      saida_paralela <= '0;
      dado_valido    <= 1'b0;
      sobrescrita    <= 1'b0;
      erro_paridade  <= 1'b0;
    end else begin
      unique case (estado)
        RECEBENDO: begin
          if (bit_valido) begin
            if (ultimo) begin
              contador    <= '0;
              estado      <= CHEIO;
              dado_valido <= 1'b1;
`ifdef PARIDADE_EN
              // Trailer bit is parity only; data is already fully shifted in.
              saida_paralela <= deslocamento;
              erro_paridade  <= ^{deslocamento, entrada_serial};
`else
              saida_paralela <= proximo;
              deslocamento   <= proximo;
`endif
            end else begin
              contador     <= contador + CW'(1);
              deslocamento <= proximo;
            end
          end
        end
        CHEIO: begin
          if (pronto_consumidor) begin
            estado        <= RECEBENDO;
            dado_valido   <= 1'b0;
            erro_paridade <= 1'b0;
            // A strobe on the accept edge starts the next word without loss.
            if (bit_valido) begin
              deslocamento <= proximo;
              contador     <= CW'(1);
            end
          end else if (bit_valido) begin
            sobrescrita <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_para_paralelo.sv
// Directed self-checking bench for serial_para_paralelo.
// Parity cases run only when PARIDADE_EN is defined.
module tb_serial_para_paralelo;

  localparam int L = 6;

  logic         clock;
  logic         reset;
  logic         limpar;
  logic         entrada_serial;
  logic         bit_valido;
  logic         pronto_consumidor;
  logic [L-1:0] saida_paralela;
  logic         dado_valido;
  logic         sobrescrita;
  logic         erro_paridade;

  int checks = 0;
  int errors = 0;

  serial_para_paralelo #(.LARGURA(L)) dut (
    .clock             (clock),
    .reset             (reset),
    .limpar            (limpar),
    .entrada_serial    (entrada_serial),
    .bit_valido        (bit_valido),
    .pronto_consumidor (pronto_consumidor),
    .saida_paralela    (saida_paralela),
    .dado_valido       (dado_valido),
    .sobrescrita       (sobrescrita),
    .erro_paridade     (erro_paridade)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic p);
    entrada_serial    = b;
    bit_valido        = 1'b1;
    pronto_consumidor = p;
    cyc(1);
    bit_valido        = 1'b0;
    pronto_consumidor = 1'b0;
    entrada_serial    = 1'b0;
  endtask

  task automatic send_par(input logic [L-1:0] w);
`ifdef PARIDADE_EN
    send_bit(^w, 1'b0);
`endif
  endtask

  task automatic send_word(input logic [L-1:0] w, input int gap);
    for (int i = 0; i < L; i++) begin
      send_bit(w[i], 1'b0);
      cyc(gap);
    end
    send_par(w);
  endtask

  task automatic accept();
    pronto_consumidor = 1'b1;
    cyc(1);
    pronto_consumidor = 1'b0;
  endtask

  logic [L-1:0] w;

  initial begin
    reset = 1'b0;
    limpar = 1'b0;
    entrada_serial = 1'b0;
    bit_valido = 1'b0;
    pronto_consumidor = 1'b0;
    cyc(2);
    chk("rst_saida", saida_paralela, 0);
    chk("rst_valido", dado_valido, 0);
    chk("rst_sobre", sobrescrita, 0);
    chk("rst_paridade", erro_paridade, 0);
    reset = 1'b1;
    cyc(1);

    // word 0x2D, back-to-back strobes
    w = 6'h2D;
    for (int i = 0; i < L - 1; i++) send_bit(w[i], 1'b0);
    chk("t1_partial", dado_valido, 0);
    send_bit(w[L-1], 1'b0);
    send_par(w);
    chk("t1_valido", dado_valido, 1);
    chk("t1_word", saida_paralela, 6'h2D);
    cyc(10);
    chk("t1_hold_v", dado_valido, 1);
    chk("t1_hold_w", saida_paralela, 6'h2D);
    accept();
    chk("t1_accept", dado_valido, 0);

    // same word with gaps between bits
    send_word(6'h2D, 3);
    chk("t2_valido", dado_valido, 1);
    chk("t2_word", saida_paralela, 6'h2D);
    accept();

    // overrun while holding 0x3F
    send_word(6'h3F, 0);
    chk("t3_word", saida_paralela, 6'h3F);
    chk("t3_sobre0", sobrescrita, 0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b0, 1'b0);
    chk("t3_sobre1", sobrescrita, 1);
    chk("t3_keep", saida_paralela, 6'h3F);
    chk("t3_keep_v", dado_valido, 1);
    accept();
    send_word(6'h01, 0);
    chk("t3_next", saida_paralela, 6'h01);
    chk("t3_sticky", sobrescrita, 1);
    accept();
    limpar = 1'b1;
    cyc(1);
    limpar = 1'b0;
    chk("t3_clr_sobre", sobrescrita, 0);
    chk("t3_clr_word", saida_paralela, 0);

    // accept and first bit of next word on the same edge
    send_word(6'h2D, 0);
    send_bit(1'b1, 1'b1);
    chk("t4_accept", dado_valido, 0);
    for (int i = 0; i < L - 1; i++) send_bit(1'b0, 1'b0);
    send_par(6'h01);
    chk("t4_valido", dado_valido, 1);
    chk("t4_word", saida_paralela, 6'h01);
    chk("t4_sobre", sobrescrita, 0);
    accept();

    // asynchronous reset mid-word
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    #2 reset = 1'b0;
    #1 chk("t5_async_w", saida_paralela, 0);
    chk("t5_async_v", dado_valido, 0);
    #1 reset = 1'b1;
    cyc(1);
    send_word(6'h15, 0);
    chk("t5_valido", dado_valido, 1);
    chk("t5_word", saida_paralela, 6'h15);
    accept();

    // synchronous clear mid-word
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b0);
    limpar = 1'b1;
    cyc(1);
    limpar = 1'b0;
    chk("t6_clr_w", saida_paralela, 0);
    send_word(6'h15, 0);
    chk("t6_valido", dado_valido, 1);
    chk("t6_word", saida_paralela, 6'h15);
    chk("t6_paridade", erro_paridade, 0);
    accept();

`ifdef PARIDADE_EN
    w = 6'h2D;
    for (int i = 0; i < L; i++) send_bit(w[i], 1'b0);
    chk("p_wait", dado_valido, 0);
    send_bit(1'b0, 1'b0);
    chk("p_ok_v", dado_valido, 1);
    chk("p_ok_w", saida_paralela, 6'h2D);
    chk("p_ok_e", erro_paridade, 0);
    accept();
    for (int i = 0; i < L; i++) send_bit(w[i], 1'b0);
    send_bit(1'b1, 1'b0);
    chk("p_bad_v", dado_valido, 1);
    chk("p_bad_w", saida_paralela, 6'h2D);
    chk("p_bad_e", erro_paridade, 1);
    accept();
    chk("p_bad_clr", erro_paridade, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
